// File: rtl/matrix_scanner_if.sv
// matrix_scanner_if: frame buffer, key lines and scan outputs of the LED/key matrix scanner.
interface matrix_scanner_if #(
    parameter int NUM_COLUMNS = 4,
    parameter int ROW_WIDTH   = 8,
    parameter int KEY_WIDTH   = 4
);
    logic [NUM_COLUMNS*ROW_WIDTH-1:0] led_data;
    logic [KEY_WIDTH-1:0]             pin_k;
    logic [ROW_WIDTH-1:0]             leds;
    logic [NUM_COLUMNS-1:0]           column;
    logic [NUM_COLUMNS*KEY_WIDTH-1:0] key_state;
    logic                             key_changed;
    logic                             frame_start;

    modport master (
        output led_data, pin_k,
        input  leds, column, key_state, key_changed, frame_start
    );

    modport slave (
        input  led_data, pin_k,
        output leds, column, key_state, key_changed, frame_start
    );
endinterface

// File: rtl/matrix_scanner.sv
// matrix_scanner: time-multiplexed LED/key matrix scanner with per-key debounce.
// Define MATRIX_SCAN_BLANK_EN to insert a dark BLANK phase before every column.
module matrix_scanner #(
    parameter int NUM_COLUMNS    = 4,
    parameter int ROW_WIDTH      = 8,
    parameter int KEY_WIDTH      = 4,
    parameter int DWELL_CYCLES   = 1200,
    parameter int BLANK_CYCLES   = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic              raw_clk,
    input logic              button_reset,
    matrix_scanner_if.slave  bus
);
`ifdef MATRIX_SCAN_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif
    localparam int NK = NUM_COLUMNS * KEY_WIDTH;
    localparam int CW = NUM_COLUMNS > 1 ? $clog2(NUM_COLUMNS) : 1;
    localparam int TW = $clog2((DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES) + 1);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [0:0] BLANK = 1'b0;
    localparam logic [0:0] DRIVE = 1'b1;
    localparam logic [CW-1:0] COL_LAST   = CW'(NUM_COLUMNS - 1);
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_SCANS - 1);

    logic [KEY_WIDTH-1:0]   k_meta, k_sync;
    logic [0:0]             state;
    logic                   live;
    logic [CW-1:0]          col_idx, col_nxt;
    logic [TW-1:0]          cnt;
    logic [NK-1:0][DW-1:0]  db_cnt, db_nxt;
    logic [NK-1:0]          key_nxt;
    logic                   sample;

    assign col_nxt = col_idx == COL_LAST ? '0 : col_idx + 1'b1;
    assign sample  = live && state == DRIVE && cnt == DWELL_LAST;

    // Only the keys of the column being sampled advance; a disagreeing sample counts up, agreement clears.
    always_comb begin
        key_nxt = bus.key_state;
        db_nxt  = db_cnt;
        for (int i = 0; i < NK; i++) begin
            if (sample && i / KEY_WIDTH == int'(col_idx)) begin
                db_nxt[i]  = (k_sync[i % KEY_WIDTH] == bus.key_state[i] || db_cnt[i] == DB_LAST) ? '0 : db_cnt[i] + 1'b1;
                key_nxt[i] = (k_sync[i % KEY_WIDTH] != bus.key_state[i] && db_cnt[i] == DB_LAST) ? ~bus.key_state[i] : bus.key_state[i];
            end
        end
    end

    always_ff @(posedge raw_clk or negedge button_reset) begin
        if (!button_reset) begin
            k_meta          <= '0;
            k_sync          <= '0;
            state           <= BLANK_EN ? BLANK : DRIVE;
            live            <= 1'b0;
            col_idx         <= '0;
            cnt             <= '0;
            db_cnt          <= '0;
            bus.leds        <= '0;
            bus.column      <= '0;
            bus.key_state   <= '0;
            bus.key_changed <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            k_meta          <= bus.pin_k;
            k_sync          <= k_meta;
            live            <= 1'b1;
            db_cnt          <= db_nxt;
            bus.key_state   <= key_nxt;
            bus.key_changed <= key_nxt != bus.key_state;
            bus.frame_start <= 1'b0;
            // Without blanking the first cycle out of reset is spent latching column 0.
            if (state == DRIVE && !live) begin
                bus.column      <= NUM_COLUMNS'(1) << col_idx;
                bus.leds        <= bus.led_data[col_idx*ROW_WIDTH +: ROW_WIDTH];
                bus.frame_start <= col_idx == '0;
            end else if (state == DRIVE) begin
                if (cnt != DWELL_LAST) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    cnt             <= '0;
                    col_idx         <= col_nxt;
                    state           <= BLANK_EN ? BLANK : DRIVE;
                    bus.column      <= BLANK_EN ? '0 : NUM_COLUMNS'(1) << col_nxt;
                    bus.leds        <= BLANK_EN ? '0 : bus.led_data[col_nxt*ROW_WIDTH +: ROW_WIDTH];
                    bus.frame_start <= !BLANK_EN && col_nxt == '0;
                end
            end else if (cnt != BLANK_LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt             <= '0;
                state           <= DRIVE;
                bus.column      <= NUM_COLUMNS'(1) << col_idx;
                bus.leds        <= bus.led_data[col_idx*ROW_WIDTH +: ROW_WIDTH];
                bus.frame_start <= col_idx == '0;
            end
        end
    end
endmodule

// File: tb/tb_matrix_scanner.sv
// tb_matrix_scanner: scoreboard bench for matrix_scanner against a cycle-index arithmetic model.
// Follows MATRIX_SCAN_BLANK_EN the same way the design does.
module tb_matrix_scanner;
    localparam int NC = 4, RW = 8, KW = 4, DWL = 4, BLK = 2, DB = 3, NK = NC * KW;
`ifdef MATRIX_SCAN_BLANK_EN
    localparam bit BL_EN = 1'b1;
`else
    localparam bit BL_EN = 1'b0;
`endif
    localparam int BL = BL_EN ? BLK : 0;
    localparam int P  = DWL + BL;
    localparam int FR = NC * P;

    typedef struct { int cyc; logic [NK-1:0] ks; } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    matrix_scanner_if #(.NUM_COLUMNS(NC), .ROW_WIDTH(RW), .KEY_WIDTH(KW)) bus ();

    matrix_scanner #(
        .NUM_COLUMNS(NC), .ROW_WIDTH(RW), .KEY_WIDTH(KW),
        .DWELL_CYCLES(DWL), .BLANK_CYCLES(BLK), .DEBOUNCE_SCANS(DB)
    ) dut (
        .raw_clk(clk),
        .button_reset(rst_n),
        .bus(bus)
    );

    int tests = 0, fails = 0;
    int n;
    logic [RW-1:0]  exp_leds;
    logic [NK-1:0]  kst;
    int             kcnt [NK];
    logic [KW-1:0]  kq [$];
    ev_t            sb [$];
    logic [NK-1:0]  fq [$];
    logic [NK-1:0]  cur_frame;

    // Position within the scan is pure arithmetic on the number of edges since reset release.
    function automatic int mpos(int nn); return BL_EN ? nn : nn - 1; endfunction
    function automatic bit is_drive(int nn); return mpos(nn) >= 0 && mpos(nn) % P >= BL; endfunction
    function automatic int col_of(int nn); return (mpos(nn) / P) % NC; endfunction
    function automatic bit is_first(int nn); return is_drive(nn) && mpos(nn) % P == BL; endfunction
    function automatic bit is_last(int nn); return is_drive(nn) && mpos(nn) % P == P - 1; endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
        end
    endtask

    task automatic check_zero(string tag);
        check({tag, "_column"}, 64'(bus.column), 64'(0));
        check({tag, "_leds"}, 64'(bus.leds), 64'(0));
        check({tag, "_key_state"}, 64'(bus.key_state), 64'(0));
        check({tag, "_key_changed"}, 64'(bus.key_changed), 64'(0));
        check({tag, "_frame_start"}, 64'(bus.frame_start), 64'(0));
    endtask

    task automatic model_reset();
        n = 0;
        kst = '0;
        foreach (kcnt[i]) kcnt[i] = 0;
        kq = '{KW'(0), KW'(0)};
        sb.delete();
        fq.delete();
        cur_frame = '0;
        exp_leds = '0;
    endtask

    // Reference model: debounce on every column sample, leds latched on column entry.
    always @(posedge clk) begin
        if (rst_n) begin
            logic [KW-1:0] smp;
            bit chg;
            int c;
            kq.push_back(bus.pin_k);
            smp = kq[0];
            kq.pop_front();
            chg = 1'b0;
            if (is_last(n)) begin
                c = col_of(n);
                for (int k = 0; k < KW; k++) begin
                    if (smp[k] == kst[c*KW+k]) kcnt[c*KW+k] = 0;
                    else begin
                        kcnt[c*KW+k]++;
                        if (kcnt[c*KW+k] == DB) begin
                            kst[c*KW+k] = ~kst[c*KW+k];
                            kcnt[c*KW+k] = 0;
                            chg = 1'b1;
                        end
                    end
                end
                if (chg) sb.push_back('{n + 1, kst});
            end
            n++;
            if (is_first(n)) exp_leds = bus.led_data[col_of(n)*RW +: RW];
            else if (!is_drive(n)) exp_leds = '0;
        end
    end

    // Monitor: scan outputs every cycle, key events popped from the scoreboard when due.
    always @(negedge clk) begin
        if (rst_n) begin
            bit due;
            ev_t e;
            check("column", 64'(bus.column), is_drive(n) ? 64'(1) << col_of(n) : 64'(0));
            check("leds", 64'(bus.leds), 64'(exp_leds));
            check("frame_start", 64'(bus.frame_start), 64'(is_first(n) && col_of(n) == 0));
            check("key_state", 64'(bus.key_state), 64'(kst));
            due = sb.size() != 0 && sb[0].cyc == n;
            check("key_changed", 64'(bus.key_changed), 64'(due));
            if (due) begin
                e = sb.pop_front();
                if (bus.key_changed) check("key_event_state", 64'(bus.key_state), 64'(e.ks));
            end
        end
    end

    task automatic step(bit rnd);
        @(posedge clk);
        #1;
        if (is_first(n)) begin
            if (col_of(n) == 0) cur_frame = fq.size() != 0 ? fq.pop_front() : '0;
            bus.pin_k = cur_frame[col_of(n)*KW +: KW];
        end
        if (rnd && $urandom_range(9) == 0) bus.led_data = $urandom;
        if (rnd && $urandom_range(11) == 0) bus.pin_k = bus.pin_k ^ (KW'(1) << $urandom_range(KW-1));
    endtask

    task automatic run_cycles(int cnt, bit rnd);
        for (int i = 0; i < cnt; i++) step(rnd);
    endtask

    initial begin
        int w;
        logic [NK-1:0] v;
        rst_n = 1'b1;
        bus.led_data = 32'hA1B2C3D4;
        bus.pin_k = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();

        run_cycles(2 * FR + 4, 1'b0);

        for (int f = 0; f < 3; f++) fq.push_back(NK'(4'b0010) << (2 * KW));
        run_cycles(5 * FR, 1'b0);
        check("press_key9", 64'(bus.key_state), 64'h0200);
        run_cycles(4 * FR, 1'b0);
        check("release_key9", 64'(bus.key_state), 64'h0);

        fq.push_back(NK'(1));
        fq.push_back(NK'(1));
        fq.push_back(NK'(0));
        run_cycles(5 * FR, 1'b0);
        check("bounce_reject", 64'(bus.key_state), 64'h0);

        w = 0;
        while (w < 30) begin
            v = NK'($urandom);
            for (int r = 0; r <= int'($urandom_range(3)); r++) begin
                fq.push_back(v);
                w++;
            end
        end
        run_cycles((w + 2) * FR, 1'b1);

        bus.led_data = 32'h5A6B7C8D;
        for (int f = 0; f < 8; f++) fq.push_back('1);
        run_cycles(4 * FR, 1'b0);
        w = 0;
        while (!(is_drive(n) && col_of(n) == NC - 1 && mpos(n) % P == BL + 1) && w < 2 * FR) begin
            step(1'b0);
            w++;
        end
        tests++;
        if (w >= 2 * FR) begin
            fails++;
            $display("FAIL wait_col3: no mid-dwell of column 3 within %0d cycles", w);
        end
        check("keys_before_reset", 64'(bus.key_state), 64'hFFFF);
        #3 rst_n = 1'b0;
        #1 check_zero("async_reset");
        repeat (2) @(posedge clk);
        check_zero("held_reset");
        #3 rst_n = 1'b1;
        model_reset();
        for (int f = 0; f < 3; f++) fq.push_back('1);
        run_cycles(2 * FR, 1'b0);
        check("keys_after_2_scans", 64'(bus.key_state), 64'h0);
        run_cycles(3 * FR, 1'b0);
        check("keys_after_3_scans", 64'(bus.key_state), 64'hFFFF);

        check("pending_events", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
